// File: rtl/fp_convert_ctrl.sv
// Sequenced two's-complement to (sign, E, F) floating-point converter with
// valid/ready on both sides: sign-magnitude, bit-serial normalise, round.
module fp_convert_ctrl #(
  parameter int IN_W    = 12,
  parameter int EXP_MAX = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] twos,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sign,
  output logic [2:0]      exp,
  output logic [3:0]      sig,
  output logic            sat,
  output logic [7:0]      conv_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAG,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [IN_W-1:0] r_twos;
  logic [IN_W-1:0] r_sh;
  logic [3:0]      r_e;
  logic            r_sign_i;
  logic            r_sat_i;

  logic            r_sign;
  logic [2:0]      r_exp;
  logic [3:0]      r_sig;
  logic            r_sat;
  logic [7:0]      r_cnt;

  logic            w_min;
  logic [IN_W-1:0] w_mag;
  logic            w_norm_done;
  logic [3:0]      w_f;
  logic            w_r;
  logic [3:0]      w_sig_n;
  logic [2:0]      w_exp_n;
  logic            w_sat_n;

  // The most negative input has no positive twin; clamp its magnitude.
  always_comb begin
    w_min = (r_twos == {1'b1, {(IN_W-1){1'b0}}});
    if (w_min)
      w_mag = {1'b0, {(IN_W-1){1'b1}}};
    else if (r_twos[IN_W-1])
      w_mag = -r_twos;
    else
      w_mag = r_twos;
  end

  assign w_norm_done = r_sh[IN_W-1] | (r_e == '0);
  assign w_f         = r_sh[IN_W-1 -: 4];
  assign w_r         = r_sh[IN_W-5];

  // Round half-up; a carry out of F renormalises, unless E is already at max.
  always_comb begin
    w_sig_n = w_f;
    w_exp_n = r_e[2:0];
    w_sat_n = r_sat_i;
    if (w_r && (&w_f) && (r_e == 4'(EXP_MAX))) begin
      w_sig_n = 4'hF;
      w_sat_n = 1'b1;
    end else if (w_r && (&w_f)) begin
      w_sig_n = 4'b1000;
      w_exp_n = r_e[2:0] + 3'd1;
    end else begin
      w_sig_n = w_f + {3'b000, w_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_MAG;
      S_MAG:   w_next = S_NORM;
      S_NORM:  if (w_norm_done) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_twos   <= '0;
      r_sh     <= '0;
      r_e      <= '0;
      r_sign_i <= 1'b0;
      r_sat_i  <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_sig    <= '0;
      r_sat    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) r_twos <= twos;
        S_MAG: begin
          r_sign_i <= r_twos[IN_W-1];
          r_sat_i  <= w_min;
          r_sh     <= w_mag;
          r_e      <= 4'd8;
        end
        S_NORM: if (!w_norm_done) begin
          r_sh <= {r_sh[IN_W-2:0], 1'b0};
          r_e  <= r_e - 4'd1;
        end
        S_ROUND: begin
          r_sign <= r_sign_i;
          r_exp  <= w_exp_n;
          r_sig  <= w_sig_n;
          r_sat  <= w_sat_n;
          r_cnt  <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign sign       = r_sign;
  assign exp        = r_exp;
  assign sig        = r_sig;
  assign sat        = r_sat;
  assign conv_count = r_cnt;

endmodule

// File: doc/fp_convert_ctrl.md
Name: fp_convert_ctrl

Overview:
- Sequenced converter: accepts a 12-bit two's-complement sample and produces the lab floating-point word. Output fields: sign 1 bit, exponent 3 bits, significand 4 bits; value = F × 2^E.
- Converts through an iterative datapath: sign-magnitude, then a one-bit-per-cycle normalising shifter, then round.
- Sits between the switch/sample source and the display/output logic.
- Uses valid/ready handshakes on both sides, so upstream and downstream may stall freely.

Parameters:
- IN_W, 12, input word width (fixed; other values unsupported).
- EXP_MAX, 7, largest exponent code.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample present on `twos`.
- in_ready  output  1  block can accept a sample.
- twos  input  12  two's-complement sample.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sign  output  1  sign bit.
- exp  output  3  exponent E.
- sig  output  4  significand F.
- sat  output  1  result was saturated (input -2048 or rounding overflow at E=7).
- conv_count  output  8  completed conversions; wraps 255→0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0.
  - sign/exp/sig/sat=0, conv_count=0.
  - Internal shift register and exponent counter cleared.
  - Reset mid-conversion abandons the sample; no output is produced.
- States: IDLE, MAG, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1 in IDLE only.
  - in_valid&in_ready at edge k: latch twos, go to MAG.
  - in_valid in any other state is ignored; the sample is not captured.
- MAG (one cycle):
  - sign = twos[11].
  - m = |twos|; twos=12'h800 gives m=2047 and sets the internal sat flag.
  - Load sh=m, E=8, go to NORM.
- NORM (one edge per cycle):
  - If sh[11]==1 or E==0, go to ROUND.
  - Otherwise sh <= sh<<1 (zero fill) and E <= E-1.
  - Let s = number of shifts, 1..8. bit11 of m is always 0, so s≥1.
- ROUND (one cycle):
  - F=sh[11:8], r=sh[7]. r is always 0 when E==0.
  - If r==1 and F==4'hF and E==7: F=4'hF, E=7, sat=1.
  - Else if r==1 and F==4'hF: F=4'b1000, E=E+1.
  - Else: F=F+r.
  - Register sign/exp/sig/sat, set out_valid=1, increment conv_count, go to DONE.
- DONE:
  - Outputs held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, go to IDLE next edge; out_valid=0 and in_ready=1 after that edge.
  - out_ready while out_valid=0 has no effect.
- Latency: out_valid rises on edge k+3+s, where s = shift count.
  - Minimum k+4 (s=1).
  - Maximum k+11 (s=8, magnitude < 16 including 0).
- Throughput: one conversion per (4+s) cycles plus the output stall, plus one IDLE cycle.
- Outputs change only in ROUND or on reset. sign/exp/sig/sat keep the last result after handshake until the next ROUND.
- Zero input: sign=0, exp=0, sig=0, sat=0.
- Negative zero does not exist; sign follows twos[11] directly.

Test Plan:
- Reset behaviour:
  - Assert rst asynchronously mid-NORM (twos=12'h00A accepted) → all outputs 0, in_ready=1 immediately, no out_valid afterwards.
  - conv_count stays 0.
- twos=12'b011000101010 (+1578), out_ready=1 → sign=0, exp=7, sig=4'b1100, sat=0.
  - out_valid exactly 4 cycles after acceptance.
  - conv_count=1.
- twos=12'b111000101010 (-470) → sign=1, exp=5, sig=4'b1111 (round-up, no carry), sat=0.
  - out_valid 6 cycles after acceptance.
- Saturation and carry cases:
  - twos=12'h800 → sign=1, exp=7, sig=4'hF, sat=1.
  - twos=12'h7FF → sign=0, exp=7, sig=4'hF, sat=1.
  - twos=12'h03F (63): F=1111, r=1 → exp=3, sig=4'b1000, sat=0.
- Small magnitudes:
  - twos=12'h000 → 0/0/0, latency 11.
  - twos=12'hFF9 (-7) → sign=1, exp=0, sig=4'b0111, latency 11.
- Handshakes:
  - Hold out_ready=0 for 20 cycles → outputs stable, in_ready=0.
  - Pulse in_valid with a new value during the stall → that value is ignored.
  - Release out_ready → in_ready=1 one cycle later.
  - Run 256 back-to-back conversions → conv_count wraps to 0.
